// File: rtl/score_keeper.sv
// score_keeper: menu/play/over game state, BCD countdown timer,
// combo-weighted BCD score and combo counter feeding the scoreboard renderer.
module score_keeper #(
    parameter int         CLK_HZ       = 50000000,
    parameter logic [7:0] GAME_SECONDS = 8'h60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic [7:0] time_left,
    output logic [9:0] combo_count,
    output logic       game_over,
    output logic       game_menu
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {MENU, PLAY, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] score_q, score_d;
    logic [9:0]      combo_q, combo_d;
    logic [7:0]      time_q, time_d;
    logic [PW-1:0]   pre_q, pre_d;

    logic       tick;
    logic [2:0] mult;
    logic [4:0] r0, r1, r2, r3;
    logic [7:0] time_dec;

    // one BCD digit plus a small addend; returns {carry, digit}
    function automatic logic [4:0] bcd_add(input logic [3:0] d, input logic [2:0] c);
        logic [4:0] s;
        s = {1'b0, d} + {2'b00, c};
        return (s > 5'd9) ? {1'b1, s[3:0] - 4'd10} : {1'b0, s[3:0]};
    endfunction

    assign tick = (pre_q == PW'(CLK_HZ - 1));
    assign mult = (combo_q <= 10'd5)  ? 3'd1 :
                  (combo_q <= 10'd13) ? 3'd2 :
                  (combo_q <= 10'd24) ? 3'd3 :
                  (combo_q <= 10'd38) ? 3'd4 : 3'd5;
    assign r0 = bcd_add(score_q[0], mult);
    assign r1 = bcd_add(score_q[1], {2'b00, r0[4]});
    assign r2 = bcd_add(score_q[2], {2'b00, r1[4]});
    assign r3 = bcd_add(score_q[3], {2'b00, r2[4]});
    assign time_dec = (time_q[3:0] == 4'd0) ? {time_q[7:4] - 4'd1, 4'd9}
                                            : {time_q[7:4], time_q[3:0] - 4'd1};

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        combo_d = combo_q;
        time_d  = time_q;
        pre_d   = pre_q;
        case (state_q)
            MENU: if (start) begin
                state_d = PLAY;
                score_d = '0;
                combo_d = '0;
                time_d  = GAME_SECONDS;
                pre_d   = '0;
            end
            PLAY: begin
                pre_d   = tick ? '0 : pre_q + 1'b1;
                time_d  = tick ? time_dec : time_q;
                state_d = (tick && time_q == 8'h01) ? OVER : PLAY;
                if (miss) begin
                    combo_d = '0;
                end else if (hit) begin
                    score_d = r3[4] ? {4{4'd9}} : {r3[3:0], r2[3:0], r1[3:0], r0[3:0]};
                    combo_d = (combo_q == 10'd1023) ? combo_q : combo_q + 10'd1;
                end
            end
            OVER: state_d = start ? MENU : OVER;
            default: state_d = MENU;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= MENU;
            score_q <= '0;
            combo_q <= '0;
            time_q  <= GAME_SECONDS;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            combo_q <= combo_d;
            time_q  <= time_d;
            pre_q   <= pre_d;
        end
    end

    assign score0      = score_q[0];
    assign score1      = score_q[1];
    assign score2      = score_q[2];
    assign score3      = score_q[3];
    assign time_left   = time_q;
    assign combo_count = combo_q;
    assign game_over   = (state_q == OVER);
    assign game_menu   = (state_q == MENU);
endmodule
